// File: rtl/id_ex_stage.sv
// RV32I decode stage and ID/EX pipeline register.
// It handles load-use hazard bubbles, flush from branch resolution and back-pressure from EX.
module id_ex_stage #(
    parameter int unsigned XLEN     = 32,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            if_valid,
    input  logic [31:0]     if_instr,
    input  logic [31:0]     if_pc,
    output logic            if_ready,
    input  logic            flush,
    input  logic            ex_stall,
    output logic [4:0]      rf_rs1,
    output logic [4:0]      rf_rs2,
    input  logic [XLEN-1:0] rf_a,
    input  logic [XLEN-1:0] rf_b,
    output logic            ex_valid,
    output logic [31:0]     ex_pc,
    output logic [XLEN-1:0] ex_a,
    output logic [XLEN-1:0] ex_b,
    output logic [XLEN-1:0] ex_imm,
    output logic [4:0]      ex_rs1,
    output logic [4:0]      ex_rs2,
    output logic [4:0]      ex_rd,
    output logic [6:0]      ex_opcode,
    output logic [2:0]      ex_funct3,
    output logic            ex_funct7b5,
    output logic            ex_mem_read,
    output logic            ex_mem_write,
    output logic            ex_reg_write,
    output logic            ex_illegal
);

    typedef enum logic [6:0] {
        OPC_LOAD   = 7'b0000011,
        OPC_FENCE  = 7'b0001111,
        OPC_OP_IMM = 7'b0010011,
        OPC_AUIPC  = 7'b0010111,
        OPC_STORE  = 7'b0100011,
        OPC_OP     = 7'b0110011,
        OPC_LUI    = 7'b0110111,
        OPC_BRANCH = 7'b1100011,
        OPC_JALR   = 7'b1100111,
        OPC_JAL    = 7'b1101111,
        OPC_SYSTEM = 7'b1110011
    } opcode_e;

    opcode_e     opc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;

    assign opc    = opcode_e'(if_instr[6:0]);
    assign rs1    = if_instr[19:15];
    assign rs2    = if_instr[24:20];
    assign rd     = if_instr[11:7];
    assign rf_rs1 = rs1;
    assign rf_rs2 = rs2;

    assign imm_i = {{20{if_instr[31]}}, if_instr[31:20]};
    assign imm_s = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
    assign imm_b = {{19{if_instr[31]}}, if_instr[31], if_instr[7],
                    if_instr[30:25], if_instr[11:8], 1'b0};
    assign imm_u = {if_instr[31:12], 12'b0};
    assign imm_j = {{11{if_instr[31]}}, if_instr[31], if_instr[19:12],
                    if_instr[20], if_instr[30:21], 1'b0};

    logic [31:0] imm;
    logic        legal;
    logic        uses_rs1;
    logic        uses_rs2;
    logic        writes_rd;
    logic        is_load;
    logic        is_store;

    always_comb begin
        imm       = '0;
        legal     = 1'b1;
        uses_rs1  = 1'b1;
        uses_rs2  = 1'b0;
        writes_rd = 1'b0;
        is_load   = 1'b0;
        is_store  = 1'b0;
        case (opc)
            OPC_LOAD: begin
                imm       = imm_i;
                writes_rd = 1'b1;
                is_load   = 1'b1;
            end
            OPC_OP_IMM: begin
                imm       = imm_i;
                writes_rd = 1'b1;
            end
            OPC_JALR: begin
                imm       = imm_i;
                writes_rd = 1'b1;
            end
            OPC_SYSTEM: imm = imm_i;
            OPC_STORE: begin
                imm      = imm_s;
                uses_rs2 = 1'b1;
                is_store = 1'b1;
            end
            OPC_BRANCH: begin
                imm      = imm_b;
                uses_rs2 = 1'b1;
            end
            OPC_LUI, OPC_AUIPC: begin
                imm       = imm_u;
                uses_rs1  = 1'b0;
                writes_rd = 1'b1;
            end
            OPC_JAL: begin
                imm       = imm_j;
                uses_rs1  = 1'b0;
                writes_rd = 1'b1;
            end
            OPC_OP: begin
                uses_rs2  = 1'b1;
                writes_rd = 1'b1;
            end
            OPC_FENCE: uses_rs1 = 1'b0;
            default:   legal = 1'b0;
        endcase
        if (if_instr[1:0] != 2'b11) begin
            legal = 1'b0;
        end
    end

    // A load in EX whose destination feeds this instruction must let the load advance first.
    logic hazard;
    assign hazard = if_valid & ex_valid & ex_mem_read & (ex_rd != 5'd0) &
                    ((uses_rs1 & (ex_rd == rs1)) | (uses_rs2 & (ex_rd == rs2)));

    assign if_ready = flush | ~(ex_stall | hazard);

    logic load_bubble;
    assign load_bubble = flush | (~ex_stall & (hazard | ~if_valid));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid     <= 1'b0;
            ex_pc        <= RESET_PC;
            ex_a         <= '0;
            ex_b         <= '0;
            ex_imm       <= '0;
            ex_rs1       <= '0;
            ex_rs2       <= '0;
            ex_rd        <= '0;
            ex_opcode    <= '0;
            ex_funct3    <= '0;
            ex_funct7b5  <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_mem_write <= 1'b0;
            ex_reg_write <= 1'b0;
            ex_illegal   <= 1'b0;
        end else if (load_bubble) begin
            ex_valid     <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_mem_write <= 1'b0;
            ex_reg_write <= 1'b0;
            ex_illegal   <= 1'b0;
        end else if (!ex_stall) begin
            ex_valid     <= 1'b1;
            ex_pc        <= if_pc;
            ex_a         <= rf_a;
            ex_b         <= rf_b;
            ex_imm       <= imm;
            ex_rs1       <= rs1;
            ex_rs2       <= rs2;
            ex_rd        <= rd;
            ex_opcode    <= if_instr[6:0];
            ex_funct3    <= if_instr[14:12];
            ex_funct7b5  <= if_instr[30];
            ex_mem_read  <= legal & is_load;
            ex_mem_write <= legal & is_store;
            ex_reg_write <= legal & writes_rd & (rd != 5'd0);
            ex_illegal   <= ~legal;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: fixed decode vectors, directed hazard, stall and flush
// sequences, and randomized traffic against a bundle-level reference model.
module tb_id_ex_stage;

    localparam logic [31:0] RPC = 32'h0000_0080;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_ready;
    logic        flush;
    logic        ex_stall;
    logic [4:0]  rf_rs1;
    logic [4:0]  rf_rs2;
    logic [31:0] rf_a;
    logic [31:0] rf_b;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [31:0] ex_a;
    logic [31:0] ex_b;
    logic [31:0] ex_imm;
    logic [4:0]  ex_rs1;
    logic [4:0]  ex_rs2;
    logic [4:0]  ex_rd;
    logic [6:0]  ex_opcode;
    logic [2:0]  ex_funct3;
    logic        ex_funct7b5;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic        ex_reg_write;
    logic        ex_illegal;

    id_ex_stage #(.XLEN(32), .RESET_PC(RPC)) dut (
        .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
        .if_ready(if_ready), .flush(flush), .ex_stall(ex_stall), .rf_rs1(rf_rs1),
        .rf_rs2(rf_rs2), .rf_a(rf_a), .rf_b(rf_b), .ex_valid(ex_valid), .ex_pc(ex_pc),
        .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_rd(ex_rd), .ex_opcode(ex_opcode), .ex_funct3(ex_funct3),
        .ex_funct7b5(ex_funct7b5), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_reg_write(ex_reg_write), .ex_illegal(ex_illegal)
    );

    always #5 clk = ~clk;

    int unsigned passed = 0;
    int unsigned total  = 0;
    logic        last_ready;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Reference model: one record per ID/EX bundle, rebuilt from instruction-level rules.
    typedef struct {
        logic        valid;
        logic [31:0] pc, a, b, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic        f7b5, mr, mw, rw, ill;
    } bundle_t;

    bundle_t m;

    function automatic bundle_t reset_bundle();
        bundle_t r;
        r = '{valid: 1'b0, pc: RPC, a: 0, b: 0, imm: 0, rs1: 0, rs2: 0, rd: 0,
              opc: 0, f3: 0, f7b5: 1'b0, mr: 1'b0, mw: 1'b0, rw: 1'b0, ill: 1'b0};
        return r;
    endfunction

    function automatic logic [31:0] ref_imm(input logic [31:0] ins);
        logic signed [31:0] s;
        s = $signed(ins);
        case (ins[6:0])
            7'h03, 7'h13, 7'h67, 7'h73: return 32'(s >>> 20);
            7'h23: return 32'((s >>> 25) <<< 5) | 32'(ins[11:7]);
            7'h63: return 32'((s >>> 31) <<< 12) | (32'(ins[7]) << 11)
                          | (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1);
            7'h37, 7'h17: return ins & 32'hFFFF_F000;
            7'h6F: return 32'((s >>> 31) <<< 20) | (32'(ins[19:12]) << 12)
                          | (32'(ins[20]) << 11) | (32'(ins[30:21]) << 1);
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic is_legal(input logic [31:0] ins);
        return ins[1:0] == 2'b11 && (ins[6:0] inside {7'h03, 7'h0F, 7'h13, 7'h17, 7'h23,
               7'h33, 7'h37, 7'h63, 7'h67, 7'h6F, 7'h73});
    endfunction

    function automatic bundle_t ref_decode(input logic [31:0] ins, pc, a, b);
        bundle_t r;
        logic ok;
        ok = is_legal(ins);
        r.valid = 1'b1; r.pc = pc; r.a = a; r.b = b; r.imm = ok ? ref_imm(ins) : 32'd0;
        r.rs1 = ins[19:15]; r.rs2 = ins[24:20]; r.rd = ins[11:7];
        r.opc = ins[6:0]; r.f3 = ins[14:12]; r.f7b5 = ins[30];
        r.mr  = ok && ins[6:0] == 7'h03;
        r.mw  = ok && ins[6:0] == 7'h23;
        r.rw  = ok && (ins[6:0] inside {7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13, 7'h33})
                && ins[11:7] != 0;
        r.ill = !ok;
        return r;
    endfunction

    function automatic logic ref_hazard(input logic v, input logic [31:0] ins);
        logic u1, u2;
        u1 = !(ins[6:0] inside {7'h37, 7'h17, 7'h6F, 7'h0F});
        u2 = ins[6:0] inside {7'h33, 7'h23, 7'h63};
        return v && m.valid && m.mr && m.rd != 0 &&
               ((u1 && m.rd == ins[19:15]) || (u2 && m.rd == ins[24:20]));
    endfunction

    task automatic compare_model();
        chk("ex_valid", 32'(ex_valid), 32'(m.valid));
        chk("ex_mem_read", 32'(ex_mem_read), 32'(m.mr));
        chk("ex_mem_write", 32'(ex_mem_write), 32'(m.mw));
        chk("ex_reg_write", 32'(ex_reg_write), 32'(m.rw));
        chk("ex_illegal", 32'(ex_illegal), 32'(m.ill));
        if (m.valid) begin
            chk("ex_pc", ex_pc, m.pc);
            chk("ex_a", ex_a, m.a);
            chk("ex_b", ex_b, m.b);
            chk("ex_imm", ex_imm, m.imm);
            chk("ex_regs", {17'd0, ex_rs1, ex_rs2, ex_rd}, {17'd0, m.rs1, m.rs2, m.rd});
            chk("ex_fields", {21'd0, ex_opcode, ex_funct3, ex_funct7b5},
                {21'd0, m.opc, m.f3, m.f7b5});
        end
    endtask

    // One clock: drive inputs, check combinational outputs, then the registered bundle.
    task automatic cycle(input logic v, input logic [31:0] ins, pc, a, b,
                         input logic st, input logic fl);
        bundle_t nxt;
        logic haz, rdy;
        if_valid = v; if_instr = ins; if_pc = pc; rf_a = a; rf_b = b;
        ex_stall = st; flush = fl;
        @(negedge clk);
        haz = ref_hazard(v, ins);
        rdy = fl || !(st || haz);
        chk("if_ready", 32'(if_ready), 32'(rdy));
        chk("rf_rs", {22'd0, rf_rs1, rf_rs2}, {22'd0, ins[19:15], ins[24:20]});
        last_ready = if_ready;
        nxt = m;
        if (fl || (!st && (haz || !v))) begin
            nxt.valid = 1'b0; nxt.mr = 1'b0; nxt.mw = 1'b0; nxt.rw = 1'b0; nxt.ill = 1'b0;
        end else if (!st) begin
            nxt = ref_decode(ins, pc, a, b);
        end
        @(posedge clk);
        #1;
        m = nxt;
        compare_model();
    endtask

    task automatic idle();
        cycle(1'b0, 32'h0000_0013, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        if_valid = 1'b0; if_instr = '0; if_pc = '0; rf_a = '0; rf_b = '0;
        ex_stall = 1'b0; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        m = reset_bundle();
        chk("reset_valid", 32'(ex_valid), 32'd0);
        chk("reset_pc", ex_pc, RPC);
        chk("reset_ctrl", {28'd0, ex_mem_read, ex_mem_write, ex_reg_write, ex_illegal}, 32'd0);
        chk("reset_imm", ex_imm, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [31:0] instr, pc, a, b, imm;
        logic [4:0]  rd;
        logic        rw, mr, mw, ill;
    } vec_t;

    vec_t vecs[13];

    initial begin
        vecs[0]  = '{32'h0050_0093, 32'h100, 32'h11, 32'h22, 32'h0000_0005, 5'd1,  1, 0, 0, 0};
        vecs[1]  = '{32'hFE20_AE23, 32'h104, 32'h33, 32'h44, 32'hFFFF_FFFC, 5'd28, 0, 0, 1, 0};
        vecs[2]  = '{32'hFE00_0CE3, 32'h108, 32'h0,  32'h0,  32'hFFFF_FFF8, 5'd25, 0, 0, 0, 0};
        vecs[3]  = '{32'h1234_52B7, 32'h10C, 32'h5,  32'h6,  32'h1234_5000, 5'd5,  1, 0, 0, 0};
        vecs[4]  = '{32'h0000_0000, 32'h110, 32'h7,  32'h8,  32'h0000_0000, 5'd0,  0, 0, 0, 1};
        vecs[5]  = '{32'h0010_0013, 32'h114, 32'h9,  32'hA,  32'h0000_0001, 5'd0,  0, 0, 0, 0};
        vecs[6]  = '{32'h0000_A103, 32'h118, 32'hB,  32'hC,  32'h0000_0000, 5'd2,  1, 1, 0, 0};
        vecs[7]  = '{32'h0080_00EF, 32'h11C, 32'hD,  32'hE,  32'h0000_0008, 5'd1,  1, 0, 0, 0};
        vecs[8]  = '{32'hFFF0_0113, 32'h120, 32'hF,  32'h1,  32'hFFFF_FFFF, 5'd2,  1, 0, 0, 0};
        vecs[9]  = '{32'h0011_01B3, 32'h124, 32'h2,  32'h3,  32'h0000_0000, 5'd3,  1, 0, 0, 0};
        vecs[10] = '{32'h0FF0_000F, 32'h128, 32'h4,  32'h5,  32'h0000_0000, 5'd0,  0, 0, 0, 0};
        vecs[11] = '{32'h0050_0090, 32'h12C, 32'h6,  32'h7,  32'h0000_0000, 5'd1,  0, 0, 0, 1};
        vecs[12] = '{32'h0000_005B, 32'h130, 32'h8,  32'h9,  32'h0000_0000, 5'd0,  0, 0, 0, 1};

        do_reset();

        foreach (vecs[i]) begin
            cycle(1'b1, vecs[i].instr, vecs[i].pc, vecs[i].a, vecs[i].b, 1'b0, 1'b0);
            chk("tbl_valid", 32'(ex_valid), 32'd1);
            chk("tbl_pc", ex_pc, vecs[i].pc);
            chk("tbl_a", ex_a, vecs[i].a);
            chk("tbl_imm", ex_imm, vecs[i].imm);
            chk("tbl_rd", 32'(ex_rd), 32'(vecs[i].rd));
            chk("tbl_ctrl", {28'd0, ex_reg_write, ex_mem_read, ex_mem_write, ex_illegal},
                {28'd0, vecs[i].rw, vecs[i].mr, vecs[i].mw, vecs[i].ill});
            idle();
        end

        // Load-use: LW x2 then ADD x3,x2,x1 gets one bubble.
        cycle(1'b1, 32'h0000_A103, 32'h200, 32'h1, 32'h2, 1'b0, 1'b0);
        cycle(1'b1, 32'h0011_01B3, 32'h204, 32'h3, 32'h4, 1'b0, 1'b0);
        chk("lu_ready", 32'(last_ready), 32'd0);
        chk("lu_bubble", {30'd0, ex_valid, ex_reg_write}, 32'd0);
        cycle(1'b1, 32'h0011_01B3, 32'h204, 32'h5, 32'h6, 1'b0, 1'b0);
        chk("lu_ready2", 32'(last_ready), 32'd1);
        chk("lu_issue", {22'd0, ex_valid, ex_rs1, ex_rs2, 2'b0} >> 2, {23'd0, 1'b1, 5'd2, 5'd1} >> 0);
        chk("lu_pc", ex_pc, 32'h204);

        // Three stall cycles hold the bundle; the pending instruction issues after release.
        cycle(1'b1, 32'h0050_0093, 32'h300, 32'hAA, 32'hBB, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            cycle(1'b1, 32'h0011_01B3, 32'h304, 32'hCC, 32'hDD, 1'b1, 1'b0);
            chk("st_ready", 32'(last_ready), 32'd0);
            chk("st_hold", {ex_pc[15:0], 8'd0, ex_a[7:0]}, {16'h0300, 8'd0, 8'hAA});
        end
        cycle(1'b1, 32'h0011_01B3, 32'h304, 32'hCC, 32'hDD, 1'b0, 1'b0);
        chk("st_release", ex_pc, 32'h304);

        // Flush beats stall and a pending hazard; the IF/ID word is dropped.
        cycle(1'b1, 32'h0000_A103, 32'h400, 32'h1, 32'h2, 1'b0, 1'b0);
        cycle(1'b1, 32'h0011_01B3, 32'h404, 32'h3, 32'h4, 1'b1, 1'b1);
        chk("fl_ready", 32'(last_ready), 32'd1);
        chk("fl_valid", 32'(ex_valid), 32'd0);
        idle();
        chk("fl_dropped", 32'(ex_valid), 32'd0);

        // Reset arriving mid-stall clears the bundle without waiting for a clock edge.
        cycle(1'b1, 32'h0000_A103, 32'h500, 32'h1, 32'h2, 1'b0, 1'b0);
        cycle(1'b1, 32'h0011_01B3, 32'h504, 32'h3, 32'h4, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_valid", 32'(ex_valid), 32'd0);
        chk("async_pc", ex_pc, RPC);
        chk("async_mr", 32'(ex_mem_read), 32'd0);
        do_reset();

        for (int n = 0; n < 400; n++) begin
            logic [6:0]  ops[13];
            logic [31:0] ins;
            ops = '{7'h03, 7'h0F, 7'h13, 7'h17, 7'h23, 7'h33, 7'h37, 7'h63, 7'h67,
                    7'h6F, 7'h73, 7'h5B, 7'h10};
            ins = $urandom;
            ins[6:0]   = ops[$urandom_range(0, 12)];
            ins[11:7]  = 5'($urandom_range(0, 3));
            ins[19:15] = 5'($urandom_range(0, 3));
            ins[24:20] = 5'($urandom_range(0, 3));
            cycle(($urandom % 5) != 0, ins, $urandom, $urandom, $urandom,
                  ($urandom % 5) == 0, ($urandom % 10) == 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1);
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode stage plus ID/EX pipeline register of the RV32I core.
- Consumes the IF/ID instruction and PC, and drives the regfile read addresses combinationally.
- Captures the returned operands, the immediate and the control fields into a registered bundle for the execute stage.
- Detects load-use hazards (stall plus bubble) and honours flush from branch resolution and back-pressure from EX.

Parameters:
- XLEN, 32, datapath/operand width (only 32 is supported).
- RESET_PC, 32'h0, value driven on ex_pc while in reset.

Ports:
- clk  input  1  core clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- if_valid  input  1  IF/ID holds a valid instruction.
- if_instr  input  32  instruction word.
- if_pc  input  32  PC of if_instr.
- if_ready  output  1  instruction accepted this cycle (combinational).
- flush  input  1  branch/jump redirect; kill in-flight decode.
- ex_stall  input  1  EX cannot accept; hold ID/EX.
- rf_rs1  output  5  regfile read address A = if_instr[19:15].
- rf_rs2  output  5  regfile read address B = if_instr[24:20].
- rf_a  input  32  regfile read data A (x0 reads 0; same-cycle writeback is forwarded inside the regfile).
- rf_b  input  32  regfile read data B.
- ex_valid  output  1  ID/EX bundle valid.
- ex_pc  output  32  registered PC.
- ex_a  output  32  registered operand A.
- ex_b  output  32  registered operand B.
- ex_imm  output  32  sign-extended immediate.
- ex_rs1, ex_rs2, ex_rd  output  5 each  register indices (instr[19:15], [24:20], [11:7]).
- ex_opcode  output  7  instr[6:0].
- ex_funct3  output  3  instr[14:12].
- ex_funct7b5  output  1  instr[30].
- ex_mem_read  output  1  LOAD.
- ex_mem_write  output  1  STORE.
- ex_reg_write  output  1  writes rd (rd≠0).
- ex_illegal  output  1  unsupported encoding.

Behaviour:
- Reset (rst_n=0, async): all ex_* outputs are 0, except ex_pc, which is RESET_PC. Normal operation resumes on the first rising edge after deassertion.
- Decode is combinational from if_instr. Latency is 1 cycle: an instruction accepted at edge N appears on ex_* after edge N.
- Immediates by opcode, sign-extended from bit 31:
  - I-type (LOAD 0000011, OP-IMM 0010011, JALR 1100111, SYSTEM 1110011): [31:20].
  - S-type (0100011): {[31:25],[11:7]}.
  - B-type (1100011): {[31],[7],[30:25],[11:8],0}.
  - U-type (LUI 0110111, AUIPC 0010111): {[31:12],12'b0}.
  - J-type (JAL 1101111): {[31],[19:12],[20],[30:21],0}.
  - R-type (OP 0110011) and FENCE (0001111): 0.
- Operand use:
  - uses_rs1 = all opcodes except LUI, AUIPC, JAL, FENCE.
  - uses_rs2 = OP, STORE, BRANCH.
- ex_reg_write = (LUI|AUIPC|JAL|JALR|LOAD|OP-IMM|OP) and rd≠0.
- Illegal: opcode not in the list above, or instr[1:0]≠2'b11. The bundle is still passed with ex_illegal=1, and ex_reg_write, ex_mem_read and ex_mem_write forced to 0.
- hazard = ex_valid & ex_mem_read & ex_rd≠0 & ((uses_rs1 & ex_rd==rs1) | (uses_rs2 & ex_rd==rs2)), qualified by if_valid.
- Per-cycle priority, highest first:
  1. flush: ex_valid←0 and if_ready=1 (the IF/ID instruction is dropped). Overrides ex_stall and hazard.
  2. ex_stall: all ID/EX registers hold and if_ready=0.
  3. hazard: ex_valid←0 (bubble; other fields don't-care, control bits forced 0) and if_ready=0. The same instruction re-decodes next cycle, when the load has moved on.
  4. if_valid: load the decoded bundle, ex_valid←1, if_ready=1.
  5. Otherwise: ex_valid←0, if_ready=1.
- Whenever ex_valid is loaded with 0, ex_mem_read, ex_mem_write, ex_reg_write and ex_illegal are also cleared, so bubbles never write state.
- rf_rs1/rf_rs2 are driven from if_instr regardless of validity. Operands are sampled from rf_a/rf_b in the same cycle, so a writeback in that cycle is captured through the regfile forwarding.
- Reset asserted mid-stall or mid-hazard clears ex_valid immediately; no pending state survives.

Test Plan:
1. Reset, then ADDI x1,x0,5 (0x00500093), pc 0x100 → one cycle later: ex_valid=1, ex_pc=0x100, ex_rd=1, ex_imm=5, ex_reg_write=1, ex_a=rf_a.
2. LW x2,0(x1) (0x0000A103), then ADD x3,x2,x1 (0x001101B3) → ADD sees if_ready=0 for 1 cycle and a bubble (ex_valid=0, ex_reg_write=0). ADD appears next cycle with ex_rs1=2, ex_rs2=1.
3. Immediates:
   - SW x2,-4(x1) (0xFE20AE23) → ex_imm=0xFFFFFFFC, ex_mem_write=1, ex_reg_write=0.
   - BEQ x0,x0,-8 (0xFE000CE3) → ex_imm=0xFFFFFFF8.
   - LUI x5,0x12345 (0x123452B7) → ex_imm=0x12345000.
4. ex_stall held 3 cycles with a valid bundle and if_valid=1 → ex_* constant, if_ready=0 throughout. Next instruction is accepted the cycle after release.
5. flush asserted together with ex_stall and a pending hazard → next cycle ex_valid=0, if_ready was 1, and the IF/ID instruction is not issued.
6. Word 0x00000000 → ex_valid=1, ex_illegal=1, all write/mem controls 0. ADDI x0,x0,1 → ex_reg_write=0.
